// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed driver for a DIGITS-wide common-anode seven-segment
// display. A free-running divider gives each digit a slot of REFRESH_DIV
// clocks. The first BLANK_CYCLES clocks of each slot keep every anode off,
// which stops the previous digit from ghosting onto the next one. Nibbles are
// decoded to active-low segment patterns, either as decimal or as hex.
// Optional leading-zero suppression and per-digit decimal points are also
// handled here.
//
// New data is captured into a pending buffer. It is copied into the displayed
// (shadow) copy only when the scan wraps back to digit 0, so a single frame
// never mixes old and new digits.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   value        nibble per digit, digit k = value[4k+3:4k] (digit 0 = LSD)
//   dp_in        decimal point request per digit, 1 = lit
//   load         single-cycle strobe, captures value/dp_in
//   hex_mode     1: nibbles 10..15 show A,b,C,d,E,F; 0: they show blank
//   lz_suppress  1: blank leading zero digits (digit 0 is never blanked)
//   blank_all    1: all anodes off (the scan keeps running)
//   seg          {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
//   an           anode enables, active-low, one-hot-low when lit
//   frame_start  one-cycle pulse at the start of each frame
//   pending      captured data not yet shown on the display
// ---------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic                  hex_mode,
    input  logic                  lz_suppress,
    input  logic                  blank_all,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start,
    output logic                  pending
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]       SEG_OFF  = 7'b1111111;

    // Scan position
    logic [DIV_W-1:0] div;
    logic [IDX_W-1:0] idx;
    logic             slot_end;
    logic             frame_end;

    // Data buffers
    logic [4*DIGITS-1:0] pend_val;
    logic [DIGITS-1:0]   pend_dp;
    logic [4*DIGITS-1:0] shadow_val;
    logic [DIGITS-1:0]   shadow_dp;

    // Next-cycle output values
    logic [DIGITS-1:0] an_nxt;
    logic [6:0]        seg_nxt;
    logic              dp_nxt;
    logic              fs_nxt;

    // Decode helpers
    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       upper_zero;
    logic       suppress;
    logic       in_blank;

    assign slot_end  = (div == DIV_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        // In decimal mode the codes 10..15 show blank, but the anode is still driven.
        if (!hex && nib > 4'd9) begin
            s = SEG_OFF;
        end
        return s;
    endfunction

    // -----------------------------------------------------------------------
    // Refresh divider and digit index
    // -----------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples values from before the edge, whatever the block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            idx <= '0;
        end else if (slot_end) begin
            div <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            div <= div + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Load handshake: pending buffer -> shadow at the frame boundary
    // -----------------------------------------------------------------------
    // NOTE: the data buffers are small flop banks, not RAM. They are reset so
    // that a reset discards loaded data and the display restarts from zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val   <= '0;
            pend_dp    <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
        end else if (load && frame_end) begin
            // The data arrives exactly on the boundary, so it bypasses the buffer.
            shadow_val <= value;
            shadow_dp  <= dp_in;
            pending    <= 1'b0;
        end else if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
            pending  <= 1'b1;
        end else if (frame_end && pending) begin
            shadow_val <= pend_val;
            shadow_dp  <= pend_dp;
            pending    <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Digit select, leading-zero detection and output decode
    // -----------------------------------------------------------------------
    // NOTE: every signal gets a default before any branch, so no latch is
    // inferred for a path that does not assign it.
    always_comb begin
        cur_nib    = 4'd0;
        cur_dp     = 1'b0;
        upper_zero = 1'b1;
        suppress   = 1'b0;
        an_nxt     = '1;
        seg_nxt    = SEG_OFF;
        dp_nxt     = 1'b1;

        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nib = shadow_val[4*k +: 4];
                cur_dp  = shadow_dp[k];
            end
        end

        // Walk down from the most significant digit. A digit is a leading
        // zero while it and everything above it are zero. Digit 0 is left out.
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (shadow_val[4*k +: 4] == 4'd0);
            if (idx == IDX_W'(k)) begin
                suppress = upper_zero;
            end
        end
        suppress = suppress && lz_suppress;

        in_blank = int'(div) < BLANK_CYCLES;

        if (!blank_all && !in_blank) begin
            an_nxt  = ~(DIGITS'(1) << idx);
            seg_nxt = suppress ? SEG_OFF : decode(cur_nib, hex_mode);
            dp_nxt  = ~cur_dp;
        end

        fs_nxt = (div == '0) && (idx == '0);
    end

    // -----------------------------------------------------------------------
    // Output registers (one cycle behind the scan position)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int RD     = 4;
    localparam int BC     = 1;
    localparam int FRAME  = RD * DIGITS;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        hex_mode;
    logic        lz_suppress;
    logic        blank_all;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;
    logic        pending;

    seg_scan_driver #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .hex_mode   (hex_mode),
        .lz_suppress(lz_suppress),
        .blank_all  (blank_all),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_start(frame_start),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural reference: scan position is derived from the cycle count,
    // and the displayed/pending data follow the frame-boundary load rules.
    int unsigned mc;
    logic [15:0] m_shadow, m_pbuf;
    logic [3:0]  m_sdp, m_pdp;
    logic        m_pending;
    logic [6:0]  dec_tab [0:15];

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dpv;
        logic        hex;
        logic        lz;
        logic [27:0] segs;   // {d3,d2,d1,d0}
        logic [3:0]  dps;    // active-low dp per digit
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mc        = 0;
        m_shadow  = '0;
        m_pbuf    = '0;
        m_sdp     = '0;
        m_pdp     = '0;
        m_pending = 1'b0;
    endtask

    // One clock: predict outputs from the model, advance the model, clock, compare.
    task automatic step();
        int          div_m, idx_m;
        logic [3:0]  e_an, nib;
        logic [6:0]  e_seg;
        logic        e_dp, e_fs, wrap;
        logic [15:0] upper;
        div_m = int'(mc % RD);
        idx_m = int'((mc / RD) % DIGITS);
        e_fs  = (mc % FRAME) == 0;
        wrap  = (mc % FRAME) == FRAME - 1;
        if (blank_all || div_m < BC) begin
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            e_an  = ~(4'b0001 << idx_m);
            upper = m_shadow >> (4 * idx_m);
            nib   = upper[3:0];
            if (lz_suppress && idx_m > 0 && upper == 16'd0) e_seg = 7'h7F;
            else if (!hex_mode && nib > 4'd9)               e_seg = 7'h7F;
            else                                            e_seg = dec_tab[nib];
            e_dp  = ~m_sdp[idx_m];
        end
        if (load && wrap) begin
            m_shadow  = value;
            m_sdp     = dp_in;
            m_pending = 1'b0;
        end else if (load) begin
            m_pbuf    = value;
            m_pdp     = dp_in;
            m_pending = 1'b1;
        end else if (wrap && m_pending) begin
            m_shadow  = m_pbuf;
            m_sdp     = m_pdp;
            m_pending = 1'b0;
        end
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("pending", 32'(pending), 32'(m_pending));
        mc++;
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic advance_to(input int unsigned phase);
        for (int i = 0; i < FRAME && (mc % FRAME) != phase; i++) step();
    endtask

    initial begin
        logic [3:0] want_an;
        int         fs_cnt;

        dec_tab[0]  = 7'b1000000; dec_tab[1]  = 7'b1111001;
        dec_tab[2]  = 7'b0100100; dec_tab[3]  = 7'b0110000;
        dec_tab[4]  = 7'b0011001; dec_tab[5]  = 7'b0010010;
        dec_tab[6]  = 7'b0000010; dec_tab[7]  = 7'b1111000;
        dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0010000;
        dec_tab[10] = 7'b0001000; dec_tab[11] = 7'b0000011;
        dec_tab[12] = 7'b1000110; dec_tab[13] = 7'b0100001;
        dec_tab[14] = 7'b0000110; dec_tab[15] = 7'b0001110;

        vecs[0] = '{16'h1234, 4'h0, 1'b1, 1'b0,
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'hF};
        vecs[1] = '{16'hABF9, 4'h0, 1'b1, 1'b0,
                    {7'b0001000, 7'b0000011, 7'b0001110, 7'b0010000}, 4'hF};
        vecs[2] = '{16'hABF9, 4'h0, 1'b0, 1'b0,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010000}, 4'hF};
        vecs[3] = '{16'h0050, 4'h0, 1'b1, 1'b1,
                    {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'hF};
        vecs[4] = '{16'h0000, 4'h0, 1'b1, 1'b1,
                    {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'hF};
        vecs[5] = '{16'h0000, 4'h0, 1'b1, 1'b0,
                    {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'hF};
        vecs[6] = '{16'h1234, 4'b0100, 1'b1, 1'b0,
                    {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1011};
        vecs[7] = '{16'h5678, 4'h0, 1'b0, 1'b0,
                    {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 4'hF};
        vecs[8] = '{16'hCDE0, 4'h0, 1'b1, 1'b1,
                    {7'b1000110, 7'b0100001, 7'b0000110, 7'b1000000}, 4'hF};
        vecs[9] = '{16'h0900, 4'b1000, 1'b1, 1'b1,
                    {7'b1111111, 7'b0010000, 7'b1000000, 7'b1000000}, 4'b0111};

        rst_n       = 1'b0;
        value       = '0;
        dp_in       = '0;
        load        = 1'b0;
        hex_mode    = 1'b1;
        lz_suppress = 1'b0;
        blank_all   = 1'b0;
        model_reset();

        // Reset state
        #12;
        check("rst_an", 32'(an), 32'h0000000F);
        check("rst_seg", 32'(seg), 32'h0000007F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("first_lit_an", 32'(an), 32'h0000000E);

        // Table-driven decode / suppression / dp vectors
        for (int v = 0; v < 10; v++) begin
            hex_mode    = vecs[v].hex;
            lz_suppress = vecs[v].lz;
            pulse_load(vecs[v].value, vecs[v].dpv);
            repeat (FRAME) step();
            repeat (FRAME) begin
                step();
                for (int k = 0; k < DIGITS; k++) begin
                    want_an = ~(4'b0001 << k);
                    if (an == want_an) begin
                        check($sformatf("vec%0d_seg_d%0d", v, k), 32'(seg), 32'(vecs[v].segs[7*k +: 7]));
                        check($sformatf("vec%0d_dp_d%0d", v, k), 32'(dp), 32'(vecs[v].dps[k]));
                    end
                end
            end
        end

        // Tear-free load: mid-frame load stays pending until the wrap
        hex_mode    = 1'b1;
        lz_suppress = 1'b0;
        pulse_load(16'h1234, 4'h0);
        repeat (2 * FRAME) step();
        advance_to(5);
        pulse_load(16'h1111, 4'h0);
        check("tf_pending_set", 32'(pending), 32'd1);
        advance_to(0);
        check("tf_pending_clear", 32'(pending), 32'd0);

        // Two loads before the wrap: the second one wins
        advance_to(3);
        pulse_load(16'h2222, 4'h0);
        step();
        pulse_load(16'h3333, 4'h0);
        advance_to(0);
        step();
        step();
        check("two_loads_an", 32'(an), 32'h0000000E);
        check("two_loads_last_wins", 32'(seg), 32'b0110000);

        // Load on the wrap cycle goes straight to shadow
        advance_to(FRAME - 1);
        pulse_load(16'h0007, 4'h0);
        check("wrap_load_pending", 32'(pending), 32'd0);
        step();
        step();
        check("wrap_load_an", 32'(an), 32'h0000000E);
        check("wrap_load_effect", 32'(seg), 32'b1111000);

        // blank_all for 10 cycles, then the scan resumes in place
        advance_to(6);
        blank_all = 1'b1;
        repeat (10) begin
            step();
            check("blank_all_an", 32'(an), 32'h0000000F);
        end
        blank_all = 1'b0;
        repeat (FRAME) step();

        // One frame_start per frame
        fs_cnt = 0;
        repeat (4 * FRAME) begin
            step();
            if (frame_start) fs_cnt++;
        end
        check("frame_start_count", 32'(fs_cnt), 32'd4);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            value = 16'($urandom);
            dp_in = 4'($urandom);
            load  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) hex_mode    = 1'($urandom);
            if ($urandom_range(0, 15) == 0) lz_suppress = 1'($urandom);
            if ($urandom_range(0, 31) == 0) blank_all   = ~blank_all;
            step();
        end
        load      = 1'b0;
        blank_all = 1'b0;

        // Reset mid-slot with data pending
        hex_mode    = 1'b1;
        lz_suppress = 1'b0;
        advance_to(5);
        pulse_load(16'h9999, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_an", 32'(an), 32'h0000000F);
        check("midrst_seg", 32'(seg), 32'h0000007F);
        check("midrst_dp", 32'(dp), 32'd1);
        check("midrst_pending", 32'(pending), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        check("post_reset_first_lit", 32'(an), 32'h0000000E);
        check("post_reset_data_lost", 32'(seg), 32'b1000000);
        repeat (FRAME) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
